// File: rtl/pipe_scheduler.sv
// pipe_scheduler
//   Sequencer for the scrolling pipe/coin datapath. It runs the game state
//   machine (initial/count/stop) and advances the horizontal scroll offset
//   once per frame. When a pipe leaves the screen, it rotates the pipe and
//   coin slot indices and draws a fresh coin height from a free-running LFSR.
//
//   Optional feature: define PIPE_SPEEDUP_EN to raise the scroll step by one
//   pixel after every 8th rotation. The step is capped at 2*SCROLL_STEP.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   Start      : begin a game / acknowledge game-over (level)
//   Collide    : bird hit a pipe or the ground (level)
//   FrameTick  : one-cycle pulse per video frame
//   Q_Initial, Q_Count, Q_Stop : one-hot state flags
//   I, IC      : pipe / coin rotation index, 0..SLOTS-1
//   XOffset    : scroll offset within the current pipe spacing
//   Advance    : one-cycle pulse when I/IC rotate
//   CoinY      : coin height for the slot just rotated in
//   Score      : pipes passed, saturating at 999
module pipe_scheduler #(
    parameter int          SLOTS        = 5,
    parameter int          PIPE_SPACING = 128,
    parameter int          SCROLL_STEP  = 2,
    parameter int          COIN_BASE    = 60,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Collide,
    input  logic       FrameTick,
    output logic       Q_Initial,
    output logic       Q_Count,
    output logic       Q_Stop,
    output logic [2:0] I,
    output logic [2:0] IC,
    output logic [9:0] XOffset,
    output logic       Advance,
    output logic [9:0] CoinY,
    output logic [9:0] Score
);

    // One-hot encoding: each state flag is a state register bit.
    typedef enum logic [2:0] {
        ST_INITIAL = 3'b001,
        ST_COUNT   = 3'b010,
        ST_STOP    = 3'b100
    } state_t;

    state_t state, state_next;

    logic [15:0] lfsr;
    logic [10:0] step;
    logic [10:0] sum;
    logic        wrap;
    logic        tick_en;
    logic        enter_init;

    // ---------------- state machine ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_INITIAL;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_INITIAL: if (Start)   state_next = ST_COUNT;
            ST_COUNT:   if (Collide) state_next = ST_STOP;
            ST_STOP:    if (Start)   state_next = ST_INITIAL;
            default:                 state_next = ST_INITIAL;
        endcase
    end

    assign Q_Initial = (state == ST_INITIAL);
    assign Q_Count   = (state == ST_COUNT);
    assign Q_Stop    = (state == ST_STOP);

    // A collision in the same cycle as a frame tick wins. The tick is dropped.
    assign tick_en    = (state == ST_COUNT) && FrameTick && !Collide;
    assign enter_init = (state == ST_STOP) && Start;

    assign sum  = {1'b0, XOffset} + step;
    assign wrap = (sum >= 11'(PIPE_SPACING));

    // ---------------- LFSR (taps 16,14,13,11), runs every clock ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // ---------------- scroll step ----------------
`ifdef PIPE_SPEEDUP_EN
    logic [2:0] adv_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step    <= 11'(SCROLL_STEP);
            adv_cnt <= '0;
        end else if (enter_init) begin
            step    <= 11'(SCROLL_STEP);
            adv_cnt <= '0;
        end else if (tick_en && wrap) begin
            adv_cnt <= adv_cnt + 3'd1;
            // This rotation is the 8th since the last step change.
            if (adv_cnt == 3'd7 && step < 11'(2 * SCROLL_STEP))
                step <= step + 11'd1;
        end
    end
`else
    assign step = 11'(SCROLL_STEP);
`endif

    // ---------------- scroll / rotation datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            I       <= '0;
            IC      <= '0;
            XOffset <= '0;
            Advance <= 1'b0;
            CoinY   <= '0;
            Score   <= '0;
        end else begin
            Advance <= 1'b0;
            if (enter_init) begin
                I       <= '0;
                IC      <= '0;
                XOffset <= '0;
                CoinY   <= '0;
                Score   <= '0;
            end else if (tick_en) begin
                if (wrap) begin
                    XOffset <= 10'(sum - 11'(PIPE_SPACING));
                    I       <= (I  == 3'(SLOTS - 1)) ? '0 : I  + 3'd1;
                    IC      <= (IC == 3'(SLOTS - 1)) ? '0 : IC + 3'd1;
                    Advance <= 1'b1;
                    CoinY   <= 10'(COIN_BASE) + {3'b000, lfsr[6:0]};
                    if (Score != 10'd999)
                        Score <= Score + 10'd1;
                end else begin
                    XOffset <= sum[9:0];
                end
            end
        end
    end

endmodule

// File: doc/pipe_scheduler.md
# pipe_scheduler

Sequencer for the scrolling pipe/coin datapath. Runs the game state machine (initial/count/stop), advances the horizontal scroll offset once per frame, and rotates the 5-slot pipe index and coin index when a pipe leaves the screen. On each rotation it draws a fresh coin height from an internal LFSR. Its outputs drive the pipe/coin height table, the obstacle renderer and the score display.

## Interface
Parameters:
- `SLOTS`, 5: number of pipe/coin slots; indices wrap `SLOTS-1 -> 0`.
- `PIPE_SPACING`, 128: horizontal pixels between consecutive pipes.
- `SCROLL_STEP`, 2: pixels of scroll per frame tick at base speed.
- `COIN_BASE`, 60: minimum coin Y coordinate.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `Start`, in, 1: level; begin a game, or acknowledge game-over.
- `Collide`, in, 1: level; bird hit a pipe or the ground.
- `FrameTick`, in, 1: one-cycle pulse per video frame.
- `Q_Initial`, `Q_Count`, `Q_Stop`, out, 1 each: one-hot state flags.
- `I`, out, 3: pipe rotation index, 0..SLOTS-1.
- `IC`, out, 3: coin rotation index, 0..SLOTS-1.
- `XOffset`, out, 10: scroll offset within the current spacing, 0..PIPE_SPACING-1.
- `Advance`, out, 1: one-cycle pulse when `I`/`IC` rotate.
- `CoinY`, out, 10: coin height for the slot just rotated in.
- `Score`, out, 10: pipes passed, saturating at 999.

## Operation
- State machine with three states:
  - INITIAL to COUNT on `Start`=1.
  - COUNT to STOP on `Collide`=1.
  - STOP to INITIAL on `Start`=1.
  - All other inputs hold the current state.
- Entering INITIAL clears `I`, `IC`, `XOffset`, `Score` and `CoinY`. The LFSR is not cleared.
- In COUNT, on each `FrameTick`:
  - If `sum = XOffset + step` is below `PIPE_SPACING`, then `XOffset <= sum`.
  - Otherwise, `XOffset <= sum - PIPE_SPACING`, and `I` and `IC` each increment modulo SLOTS.
  - On that rotation, `Advance` pulses, `Score` increments (saturating at 999), and `CoinY <= COIN_BASE + lfsr[6:0]`, giving the range COIN_BASE..COIN_BASE+127.
- `sum` is computed at 11 bits, so there is no overflow.
- `step` equals `SCROLL_STEP` unless changed by the configured feature.
- In STOP, all counters freeze. `FrameTick` is ignored.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11. It shifts every clock in every state, so seed variation comes from human timing.
- Simultaneous events:
  - `Collide` and `FrameTick` in the same COUNT cycle: the collision wins. The state goes to STOP, with no offset update and no `Advance`.
  - `Start` while in COUNT: ignored.
  - `Start` and `Collide` together while in COUNT: go to STOP.

## Timing
- All outputs are registered.
- Reset values:
  - `Q_Initial`=1, `Q_Count`=0, `Q_Stop`=0.
  - `I`=0, `IC`=0, `XOffset`=0, `Advance`=0, `CoinY`=0, `Score`=0.
  - LFSR=`LFSR_SEED`.
- State flags change on the clock edge after the qualifying input is sampled (1-cycle latency).
- `XOffset`, `I`, `IC`, `CoinY` and `Score` update on the edge that samples `FrameTick`. `Advance` is high for exactly that following cycle.
- `CoinY` changes only together with `Advance`, so it is valid whenever `Advance`=1.
- Reset asserted mid-game takes effect immediately (asynchronous) and returns the block to INITIAL. No pending `Advance` survives.

## Configuration
- `PIPE_SPEEDUP_EN` defined:
  - `step` starts at `SCROLL_STEP`.
  - `step` increments by 1 after every 8th `Advance`, capped at `2*SCROLL_STEP`.
  - `step` returns to `SCROLL_STEP` on entering INITIAL or on reset.
  - A 3-bit advance counter is added internally.
- `PIPE_SPEEDUP_EN` undefined: `step` is constant `SCROLL_STEP`, and no counter logic is generated.

## Test plan
- **Reset and start:** assert `reset`, release, pulse `Start` -> `Q_Initial`=1 before the pulse, `Q_Count`=1 one cycle later, all counters 0.
- **Rotation:** 64 `FrameTick`s in COUNT at defaults -> `XOffset` steps 0, 2, ..., 126; on the 64th tick, `XOffset`=0, `I`=1, `IC`=1, `Score`=1, `Advance` high for 1 cycle, `CoinY` in 60..187.
- **Index wrap:** 5×64 ticks -> `I` and `IC` sequence 1, 2, 3, 4, 0; `Score`=5.
- **Simultaneous events:** `Collide` and `FrameTick` together at `XOffset`=126 -> `Q_Stop`=1, `XOffset` stays 126, no `Advance`. Further ticks change nothing. `Start` -> `Q_Initial`=1, counters cleared.
- **Async reset mid-game:** assert `reset` mid-COUNT between clock edges -> outputs reach reset values before the next edge.
- **With `PIPE_SPEEDUP_EN`:** after 8 advances, `XOffset` increments by 3 per tick; after 16 advances, by 4; after 24 and beyond, still 4. Without the macro, the increment stays 2 throughout.
